// File: rtl/be_native_arbiter_pkg.sv
// Shared definitions for the native back-end arbiter: FSM encodings and the
// round-robin pointer helper.
package be_native_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    // Next round-robin slot after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/be_native_arbiter_rr_prio_enc.sv
// Circular priority encoder: returns the first asserted request at or after
// ptr, wrapping around, plus a found flag.
module rr_prio_enc #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    int j;

    // Scan from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                idx   = ID_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/be_native_arbiter.sv
// Round-robin arbiter sharing one native memory port between N_MASTERS
// requesters; grants are held for contiguous bursts, bounded by MAX_HOLD.
module be_native_arbiter
    import be_native_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_HOLD  = 8,
    localparam int NBYTES   = DATA_W / 8,
    localparam int ID_W     = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*NBYTES-1:0]   m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          mem_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [NBYTES-1:0]             mem_wstrb,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [0:0]      state;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] rr_ptr;
    logic [HC_W-1:0] hold_cnt;

    logic [ID_W-1:0] pick;
    logic            pick_found;
    logic            grant;
    logic            own_valid;
    logic            xfer;
    logic            others_req;
    logic            yield;

    logic [N_MASTERS-1:0]             owner_oh;
    logic [N_MASTERS-1:0][ADDR_W-1:0] addr_v;
    logic [N_MASTERS-1:0][DATA_W-1:0] wdata_v;
    logic [N_MASTERS-1:0][NBYTES-1:0] wstrb_v;

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_master
        assign addr_v[g]   = m_addr[g*ADDR_W +: ADDR_W];
        assign wdata_v[g]  = m_wdata[g*DATA_W +: DATA_W];
        assign wstrb_v[g]  = m_wstrb[g*NBYTES +: NBYTES];
        assign owner_oh[g] = (owner == ID_W'(g));
    end

    rr_prio_enc #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_enc (
        .req   (m_valid),
        .ptr   (rr_ptr),
        .idx   (pick),
        .found (pick_found)
    );

    assign grant      = (state == ARB_GRANT);
    assign own_valid  = m_valid[owner];
    assign others_req = |(m_valid & ~owner_oh);
    assign xfer       = mem_valid & mem_ready;
    // Yield only on the beat that completes the hold window, never mid-transfer.
    assign yield      = xfer && (hold_cnt == HOLD_LAST) && others_req;

    assign mem_valid = grant & own_valid;
    assign mem_addr  = grant ? addr_v[owner]  : '0;
    assign mem_wdata = grant ? wdata_v[owner] : '0;
    assign mem_wstrb = grant ? wstrb_v[owner] : '0;
    assign m_ready   = (grant & mem_ready) ? owner_oh : '0;
    assign m_rdata   = mem_rdata;
    assign grant_id  = owner;
    assign busy      = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_found) begin
                owner    <= pick;
                rr_ptr   <= ID_W'(rr_next(int'(pick), N_MASTERS));
                hold_cnt <= '0;
                state    <= ARB_GRANT;
            end
        end else begin
            if (xfer && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + HC_W'(1);
            if (!own_valid || yield) state <= ARB_IDLE;
        end
    end

endmodule
